// File: rtl/stage1_pkg.sv
// Shared types and constants for the stage-1 compression datapath.
package stage1_pkg;

    localparam int DICT_ENTRY = 16;
    localparam int DICT_WORD  = 32;
    localparam int PTR_W      = $clog2(DICT_ENTRY);

    // Block sequencing states of the match controller
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/stage1_inflight_tracker.sv
// Valid-flag shift register that follows items through a fixed-latency
// pipeline which only advances on enabled cycles. The empty flag looks one
// update ahead: it is high when no flag will remain after this cycle, which
// lets a controller finish a drain without an extra idle cycle.
module stage1_inflight_tracker #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_flag,
    output logic out_valid,
    output logic empty
);

    logic [DEPTH-1:0] flag_reg;
    logic [DEPTH-1:0] flag_next;

    // Stage 0 takes the new flag; every other stage takes its predecessor
    assign flag_next[0] = en ? in_flag : flag_reg[0];
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        assign flag_next[gi] = en ? flag_reg[gi-1] : flag_reg[gi];
    end

    // Flag register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg <= '0;
        end else begin
            flag_reg <= flag_next;
        end
    end

    assign out_valid = flag_reg[DEPTH-1];
    assign empty     = (flag_next == '0);

endmodule

// File: rtl/stage1_match_ctrl.sv
// Sequencing controller for the stage-1 matching stage: block start/clear,
// input handshake, dictionary write pointer and valid mask, in-flight
// tracking and output backpressure.
module stage1_match_ctrl #(
    parameter int WIDTH       = 64,
    parameter int DICT_ENTRY  = stage1_pkg::DICT_ENTRY,
    parameter int PIPE_LAT    = 2,
    parameter int BLOCK_PAIRS = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [WIDTH-1:0]              i_word,
    output logic [WIDTH-1:0]              o_dp_word,
    output logic                          o_dp_en,
    output logic                          o_dict_clear,
    output logic                          o_dict_we,
    output logic [$clog2(DICT_ENTRY)-1:0] o_wr_ptr,
    output logic [DICT_ENTRY-1:0]         o_entry_valid,
    output logic                          o_dict_full,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_block_done,
    output logic                          o_busy
);

    import stage1_pkg::ctrl_state_t;
    import stage1_pkg::IDLE;
    import stage1_pkg::CLEAR;
    import stage1_pkg::RUN;
    import stage1_pkg::DRAIN;
    import stage1_pkg::DONE;

    localparam int PTR_W = $clog2(DICT_ENTRY);
    localparam int CNT_W = $clog2(BLOCK_PAIRS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_PAIRS);

    ctrl_state_t           state_reg;
    ctrl_state_t           state_next;
    logic [CNT_W-1:0]      issued_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [DICT_ENTRY-1:0] mask_reg;
    logic [DICT_ENTRY-1:0] mask_set;
    logic [WIDTH-1:0]      dp_word_reg;
    logic                  we_reg;
    logic                  dp_en;
    logic                  xfer;
    logic                  pipe_empty;

    // Pipeline freezes only while a valid result waits on the packer
    assign dp_en = !(o_out_valid && !i_out_ready);
    assign xfer  = i_valid && o_ready;

    stage1_inflight_tracker #(
        .DEPTH (PIPE_LAT)
    ) u_tracker (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .en        (dp_en),
        .in_flag   (xfer),
        .out_valid (o_out_valid),
        .empty     (pipe_empty)
    );

    // Next-state logic; RUN may skip DRAIN when the pipe empties at once
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (issued_reg == LAST_CNT) state_next = pipe_empty ? DONE : DRAIN;
            DRAIN:   if (pipe_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Forwarded pair and its write strobe; both hold while stalled
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dp_word_reg <= '0;
            we_reg      <= 1'b0;
        end else begin
            if (xfer) begin
                dp_word_reg <= i_word;
            end
            if (dp_en) begin
                we_reg <= xfer;
            end
        end
    end

    // Mask bits for the two entries the pending write fills
    always_comb begin
        mask_set = '0;
        mask_set[wr_ptr_reg]               = 1'b1;
        mask_set[wr_ptr_reg + PTR_W'(1)]   = 1'b1;
    end

    // Block bookkeeping: pair count, FIFO write pointer, valid-entry mask
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            issued_reg <= '0;
            wr_ptr_reg <= '0;
            mask_reg   <= '0;
        end else if (state_reg == CLEAR) begin
            issued_reg <= '0;
            wr_ptr_reg <= '0;
            mask_reg   <= '0;
        end else begin
            if (xfer) begin
                issued_reg <= issued_reg + CNT_W'(1);
            end
            if (o_dict_we) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(2);
                mask_reg   <= mask_reg | mask_set;
            end
        end
    end

    assign o_ready       = (state_reg == RUN) && dp_en && (issued_reg < LAST_CNT);
    assign o_dp_word     = dp_word_reg;
    assign o_dp_en       = dp_en;
    assign o_dict_clear  = (state_reg == CLEAR);
    assign o_dict_we     = we_reg && dp_en;
    assign o_wr_ptr      = wr_ptr_reg;
    assign o_entry_valid = mask_reg;
    assign o_dict_full   = &mask_reg;
    assign o_block_done  = (state_reg == DONE);
    assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_stage1_match_ctrl.sv
// Self-checking bench for stage1_match_ctrl: a transaction-level model
// (queue of pair ages, write count) is compared every cycle, plus
// directed timing and boundary expectations per block.
module tb_stage1_match_ctrl;

    localparam int WIDTH       = 64;
    localparam int DICT_ENTRY  = 16;
    localparam int PIPE_LAT    = 2;
    localparam int BLOCK_PAIRS = 32;
    localparam int PTR_W       = $clog2(DICT_ENTRY);
    localparam logic [63:0] SPECIAL = 64'h11223344_AABBCCDD;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic                  valid = 1'b0;
    logic                  out_ready = 1'b1;
    logic [WIDTH-1:0]      word = '0;
    logic                  o_ready, o_dp_en, o_dict_clear, o_dict_we;
    logic                  o_dict_full, o_out_valid, o_block_done, o_busy;
    logic [WIDTH-1:0]      o_dp_word;
    logic [PTR_W-1:0]      o_wr_ptr;
    logic [DICT_ENTRY-1:0] o_entry_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state
    int          m_phase;
    int          ages[$];
    bit          m_pend;
    int          m_writes;
    int          m_acc;
    logic [63:0] m_word;

    // observation logs (cycle stamps)
    int               start_cyc[$];
    int               clear_cyc[$];
    int               xfer_cyc[$];
    int               cons_cyc[$];
    int               done_cyc[$];
    int               we_cyc[$];
    logic [PTR_W-1:0] we_ptr[$];
    bit               we_full[$];
    logic [63:0]      we_word[$];

    stage1_match_ctrl #(
        .WIDTH       (WIDTH),
        .DICT_ENTRY  (DICT_ENTRY),
        .PIPE_LAT    (PIPE_LAT),
        .BLOCK_PAIRS (BLOCK_PAIRS)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_valid       (valid),
        .o_ready       (o_ready),
        .i_word        (word),
        .o_dp_word     (o_dp_word),
        .o_dp_en       (o_dp_en),
        .o_dict_clear  (o_dict_clear),
        .o_dict_we     (o_dict_we),
        .o_wr_ptr      (o_wr_ptr),
        .o_entry_valid (o_entry_valid),
        .o_dict_full   (o_dict_full),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (out_ready),
        .o_block_done  (o_block_done),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        m_phase  = PH_IDLE;
        ages.delete();
        m_pend   = 1'b0;
        m_writes = 0;
        m_acc    = 0;
        m_word   = '0;
    endtask

    // One model evaluation per cycle: compare, log, then advance
    task automatic model_cycle();
        bit e_ov, e_en, e_rdy, e_we, e_full, xf;
        int e_ptr, acc_before;
        logic [DICT_ENTRY-1:0] e_mask;
        if (!rst_n) model_clear();
        e_ov   = (ages.size() > 0) ? (ages[0] == PIPE_LAT) : 1'b0;
        e_en   = !(e_ov && !out_ready);
        e_rdy  = (m_phase == PH_RUN) && e_en && (m_acc < BLOCK_PAIRS);
        e_we   = m_pend && e_en;
        e_ptr  = (2 * m_writes) % DICT_ENTRY;
        e_full = (2 * m_writes >= DICT_ENTRY);
        for (int k = 0; k < DICT_ENTRY; k++) e_mask[k] = (k < 2 * m_writes);
        chk("m_ready",       64'(o_ready),       64'(e_rdy));
        chk("m_dp_en",       64'(o_dp_en),       64'(e_en));
        chk("m_dict_clear",  64'(o_dict_clear),  64'(m_phase == PH_CLEAR));
        chk("m_dict_we",     64'(o_dict_we),     64'(e_we));
        chk("m_wr_ptr",      64'(o_wr_ptr),      64'(e_ptr));
        chk("m_entry_valid", 64'(o_entry_valid), 64'(e_mask));
        chk("m_dict_full",   64'(o_dict_full),   64'(e_full));
        chk("m_out_valid",   64'(o_out_valid),   64'(e_ov));
        chk("m_block_done",  64'(o_block_done),  64'(m_phase == PH_DONE));
        chk("m_busy",        64'(o_busy),        64'(m_phase != PH_IDLE));
        chk("m_dp_word",     o_dp_word,          m_word);
        if (rst_n) begin
            if (start && !o_busy) start_cyc.push_back(cyc);
            if (o_dict_clear) clear_cyc.push_back(cyc);
            if (valid && o_ready) xfer_cyc.push_back(cyc);
            if (o_out_valid && out_ready) cons_cyc.push_back(cyc);
            if (o_block_done) done_cyc.push_back(cyc);
            if (o_dict_we) begin
                we_cyc.push_back(cyc);
                we_ptr.push_back(o_wr_ptr);
                we_full.push_back(o_dict_full);
                we_word.push_back(o_dp_word);
            end
            xf = valid && e_rdy;
            acc_before = m_acc;
            if (e_en) begin
                foreach (ages[k]) ages[k] = ages[k] + 1;
                if (ages.size() > 0 && ages[0] > PIPE_LAT) ages.delete(0);
                if (xf) ages.push_back(1);
                m_pend = xf;
            end
            if (e_we) m_writes++;
            if (xf) begin
                m_word = word;
                m_acc++;
            end
            case (m_phase)
                PH_IDLE:  if (start) m_phase = PH_CLEAR;
                PH_CLEAR: begin m_phase = PH_RUN; m_writes = 0; m_acc = 0; end
                PH_RUN:   if (acc_before == BLOCK_PAIRS) m_phase = (ages.size() == 0) ? PH_DONE : PH_DRAIN;
                PH_DRAIN: if (ages.size() == 0) m_phase = PH_DONE;
                default:  m_phase = PH_IDLE;
            endcase
        end
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid and out_ready
    task automatic run_block(input int mode, input bit special, input int stall_at, input int reset_at);
        int sent, budget, stall_left, n;
        int x0, c0, d0, k0, s0, w0;
        bit stalled_once;
        logic [63:0] last_word;
        x0 = xfer_cyc.size(); c0 = cons_cyc.size(); d0 = done_cyc.size();
        k0 = clear_cyc.size(); s0 = start_cyc.size(); w0 = we_cyc.size();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("clear_pulse", 64'(o_dict_clear), 64'd1);
        @(posedge clk); #1;
        chk("new_block_ptr0",  64'(o_wr_ptr),      64'd0);
        chk("new_block_mask0", 64'(o_entry_valid), 64'd0);
        chk("new_block_full0", 64'(o_dict_full),   64'd0);
        sent = 0; budget = 0; stall_left = 0; stalled_once = 1'b0; last_word = '0;
        while (sent < BLOCK_PAIRS && budget < 3000) begin
            if (stall_at >= 0 && sent == stall_at && !stalled_once) begin
                stall_left = 5;
                stalled_once = 1'b1;
            end
            case (mode)
                0:       valid = 1'b1;
                1:       valid = (budget % 2 == 0);
                default: valid = 1'($urandom_range(0, 1));
            endcase
            word = (special && sent == 0) ? SPECIAL : {$urandom, $urandom};
            if (stall_left > 0) out_ready = 1'b0;
            else if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
            start = special && (sent == 5);
            #2;
            if (stall_left > 0) begin
                chk("stall_dp_en", 64'(o_dp_en),     64'd0);
                chk("stall_ready", 64'(o_ready),     64'd0);
                chk("stall_we",    64'(o_dict_we),   64'd0);
                chk("stall_ov",    64'(o_out_valid), 64'd1);
                chk("stall_ptr",   64'(o_wr_ptr),    64'((2 * (stall_at - 1)) % DICT_ENTRY));
                chk("stall_word",  o_dp_word,        last_word);
                stall_left--;
            end
            if (valid && o_ready) begin
                sent++;
                last_word = word;
            end
            if (reset_at >= 0 && sent == reset_at) break;
            @(posedge clk); #1;
            budget++;
        end
        chk("feed_budget", 64'(budget < 3000), 64'd1);
        start = 1'b0;
        if (reset_at >= 0) begin
            @(posedge clk); #2;
            rst_n = 1'b0;
            valid = 1'b0;
            #1;
            chk("arst_busy",   64'(o_busy),        64'd0);
            chk("arst_ready",  64'(o_ready),       64'd0);
            chk("arst_dp_en",  64'(o_dp_en),       64'd1);
            chk("arst_we",     64'(o_dict_we),     64'd0);
            chk("arst_ptr",    64'(o_wr_ptr),      64'd0);
            chk("arst_mask",   64'(o_entry_valid), 64'd0);
            chk("arst_full",   64'(o_dict_full),   64'd0);
            chk("arst_ov",     64'(o_out_valid),   64'd0);
            chk("arst_word",   o_dp_word,          64'd0);
            chk("arst_xfers",  64'(xfer_cyc.size() - x0), 64'(reset_at));
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk("arst_no_done", 64'(done_cyc.size() - d0), 64'd0);
            return;
        end
        valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (o_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_budget", 64'(n < 200), 64'd1);
        chk("xfer_count",  64'(xfer_cyc.size() - x0),  64'(BLOCK_PAIRS));
        chk("out_count",   64'(cons_cyc.size() - c0),  64'(BLOCK_PAIRS));
        chk("we_count",    64'(we_cyc.size() - w0),    64'(BLOCK_PAIRS));
        chk("done_count",  64'(done_cyc.size() - d0),  64'd1);
        chk("clear_count", 64'(clear_cyc.size() - k0), 64'd1);
        chk("clear_lat",   64'(clear_cyc[k0] - start_cyc[s0]), 64'd1);
        if (mode == 0) begin
            chk("first_out_lat", 64'(cons_cyc[c0] - xfer_cyc[x0]), 64'(PIPE_LAT));
            chk("done_lat", 64'(done_cyc[d0] - xfer_cyc[x0 + BLOCK_PAIRS - 1]), 64'(PIPE_LAT + 1));
            chk("we1_ptr",  64'(we_ptr[w0]),      64'd0);
            chk("we8_ptr",  64'(we_ptr[w0 + 7]),  64'd14);
            chk("we8_full", 64'(we_full[w0 + 7]), 64'd0);
            chk("we9_full", 64'(we_full[w0 + 8]), 64'd1);
            chk("we9_ptr",  64'(we_ptr[w0 + 8]),  64'd0);
            if (special) chk("we1_word", we_word[w0], SPECIAL);
        end
        if (mode == 1) begin
            for (int k = 0; k < BLOCK_PAIRS; k++) begin
                chk("bubble_we_lat", 64'(we_cyc[w0 + k] - xfer_cyc[x0 + k]), 64'd1);
                chk("bubble_ptr",    64'(we_ptr[w0 + k]), 64'((2 * k) % DICT_ENTRY));
            end
        end
    endtask

    initial begin
        model_clear();
        fork
            forever begin
                @(negedge clk);
                cyc++;
                model_cycle();
            end
        join_none
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dp_en", 64'(o_dp_en), 64'd1);
        chk("reset_busy",  64'(o_busy),  64'd0);
        rst_n = 1'b1;
        run_block(0, 1'b1, -1, -1);   // basic, wrap/full, start ignored in RUN
        run_block(0, 1'b0, 10, -1);   // 5-cycle backpressure mid-block
        run_block(1, 1'b0, -1, -1);   // input bubbles
        run_block(0, 1'b0, -1, 10);   // reset after 10 pairs
        run_block(0, 1'b1, -1, -1);   // clean block after the abort
        run_block(2, 1'b0, -1, -1);   // random valid / out_ready
        run_block(2, 1'b0, -1, -1);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
